// File: rtl/neuron_accum_activate.sv
// Accumulates NUM_CHUNKS signed partial sums, adds a bias, rounds half-up and saturates to an OUT_W pixel.
// Build option: define NEURON_RELU_EN for ReLU + unsigned saturation (default: linear, signed saturation).
module neuron_accum_activate #(
  parameter int NUM_CHUNKS = 4,
  parameter int PSUM_W     = 26,
  parameter int FRAC_BITS  = 16,
  parameter int ACC_W      = 32,
  parameter int OUT_W      = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [PSUM_W-1:0] in_psum,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PSUM_W-1:0] bias,
  input  logic              clear,
  output logic [OUT_W-1:0]  out_pixel,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic [1:0]        dbg_state
);

  // Handshakes: a beat transfers on a rising edge when in_valid && in_ready; the pixel is
  // consumed when out_valid && out_ready. clear overrides both handshakes in the same cycle.

  localparam int CNT_W = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_CHUNKS - 1);
  // One guard bit above the accumulator so bias and rounding offset cannot wrap.
  localparam int SUM_W = ACC_W + 1;
  localparam logic [SUM_W-1:0] HALF = {{(SUM_W-1){1'b0}}, 1'b1} << (FRAC_BITS - 1);

  typedef enum logic [1:0] {
    ACCUM  = 2'd0,
    FINISH = 2'd1,
    HOLD   = 2'd2
  } state_e;

  state_e                   state_q, state_d;
  logic [ACC_W-1:0]         acc_q, acc_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [OUT_W-1:0]         pix_q, pix_d;
  logic                     ov_q, ov_d;
  logic signed [SUM_W-1:0]  sum_v;
  logic signed [SUM_W-1:0]  rnd_v;
  logic [OUT_W-1:0]         sat_pix;

  always_comb begin
    sum_v = {{(SUM_W-ACC_W){acc_q[ACC_W-1]}}, acc_q}
          + {{(SUM_W-PSUM_W){bias[PSUM_W-1]}}, bias}
          + HALF;
    rnd_v = sum_v >>> FRAC_BITS;
`ifdef NEURON_RELU_EN
    if (rnd_v[SUM_W-1]) begin
      sat_pix = '0;
    end else if (rnd_v > $signed(SUM_W'((2 ** OUT_W) - 1))) begin
      sat_pix = '1;
    end else begin
      sat_pix = rnd_v[OUT_W-1:0];
    end
`else
    if (rnd_v > $signed(SUM_W'((2 ** (OUT_W - 1)) - 1))) begin
      sat_pix = {1'b0, {(OUT_W-1){1'b1}}};
    end else if (rnd_v < $signed(~SUM_W'((2 ** (OUT_W - 1)) - 1))) begin
      sat_pix = {1'b1, {(OUT_W-1){1'b0}}};
    end else begin
      sat_pix = rnd_v[OUT_W-1:0];
    end
`endif
  end

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    pix_d    = pix_q;
    ov_d     = ov_q;
    in_ready = (state_q == ACCUM);
    if (clear) begin
      state_d = ACCUM;
      acc_d   = '0;
      cnt_d   = '0;
      ov_d    = 1'b0;
    end else begin
      case (state_q)
        ACCUM: begin
          if (in_valid) begin
            acc_d = acc_q + {{(ACC_W-PSUM_W){in_psum[PSUM_W-1]}}, in_psum};
            if (cnt_q == LAST) begin
              cnt_d   = '0;
              state_d = FINISH;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
        FINISH: begin
          pix_d   = sat_pix;
          ov_d    = 1'b1;
          state_d = HOLD;
        end
        HOLD: begin
          if (out_ready) begin
            ov_d    = 1'b0;
            acc_d   = '0;
            state_d = ACCUM;
          end
        end
        default: begin
          state_d = ACCUM;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ACCUM;
      acc_q   <= '0;
      cnt_q   <= '0;
      pix_q   <= '0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      pix_q   <= pix_d;
      ov_q    <= ov_d;
    end
  end

  assign out_pixel = pix_q;
  assign out_valid = ov_q;
  assign busy      = (state_q != ACCUM) || (cnt_q != '0);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_neuron_accum_activate.sv
// Table-driven bench for neuron_accum_activate plus directed multi-cycle sequences.
module tb_neuron_accum_activate;

`ifdef NEURON_RELU_EN
  localparam bit RELU = 1'b1;
`else
  localparam bit RELU = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [25:0] in_psum = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [25:0] bias = '0;
  logic        clear = 1'b0;
  logic [9:0]  out_pixel;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        busy;
  logic [1:0]  dbg_state;

  int errors = 0;
  int checks = 0;

  neuron_accum_activate dut (
    .clk       (clk),
    .rst       (rst),
    .in_psum   (in_psum),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .bias      (bias),
    .clear     (clear),
    .out_pixel (out_pixel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  typedef struct {
    string       name;
    logic [25:0] p0, p1, p2, p3, b;
    logic [9:0]  e_lin, e_relu;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [25:0] qi(input int v);
    return 26'(v * 65536);
  endfunction

  function automatic logic [25:0] raw(input int v);
    return 26'(v);
  endfunction

  task automatic add_vec(input string nm, input logic [25:0] p0, p1, p2, p3, b,
                         input logic [9:0] e_lin, e_relu);
    vec_t v;
    v.name = nm; v.p0 = p0; v.p1 = p1; v.p2 = p2; v.p3 = p3; v.b = b;
    v.e_lin = e_lin; v.e_relu = e_relu;
    vecs.push_back(v);
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Offers one beat after 'gap' idle cycles; returns #1 after the accepting edge.
  task automatic feed(input logic [25:0] p, input int gap);
    repeat (gap) @(posedge clk);
    #1;
    in_valid = 1'b1;
    in_psum  = p;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_psum  = 26'($urandom);
  endtask

  // Called #1 after the edge that accepted the last beat (FINISH cycle).
  task automatic finish_pixel(input string nm, input logic [9:0] exp);
    check({nm, "_lat_finish_ov"}, 32'(out_valid), 32'd0);
    check({nm, "_busy"}, 32'(busy), 32'd1);
    @(posedge clk);
    #1;
    check({nm, "_ov"}, 32'(out_valid), 32'd1);
    check({nm, "_pix"}, 32'(out_pixel), 32'(exp));
    check({nm, "_in_ready_hold"}, 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check({nm, "_consumed"}, 32'(out_valid), 32'd0);
    check({nm, "_in_ready_back"}, 32'(in_ready), 32'd1);
  endtask

  task automatic run_pixel(input string nm, input logic [25:0] p0, p1, p2, p3, b,
                           input logic [9:0] exp, input bit gaps);
    bias = b;
    feed(p0, gaps ? $urandom_range(0, 2) : 0);
    feed(p1, gaps ? $urandom_range(0, 2) : 0);
    feed(p2, gaps ? $urandom_range(0, 2) : 0);
    feed(p3, gaps ? $urandom_range(0, 2) : 0);
    finish_pixel(nm, exp);
  endtask

  initial begin
    add_vec("sum800",     qi(200), qi(200), qi(200), qi(200), '0, 10'd511, 10'd800);
    add_vec("sat_hi",     qi(500), qi(500), qi(500), qi(500), '0, 10'd511, 10'd1023);
    add_vec("neg400",     qi(-100), qi(-100), qi(-100), qi(-100), '0, 10'h270, 10'd0);
    add_vec("rnd_half",   raw(32'h8000), '0, '0, '0, '0, 10'd1, 10'd1);
    add_vec("rnd_below",  raw(32'h7FFF), '0, '0, '0, '0, 10'd0, 10'd0);
    add_vec("bias_neg",   qi(2), '0, '0, '0, qi(-1), 10'd1, 10'd1);
    add_vec("mixed78",    qi(100), qi(-30), qi(5), raw(32'h4000), qi(3), 10'd78, 10'd78);
    add_vec("neg_1p5",    raw(-32'sh18000), '0, '0, '0, '0, 10'h3FF, 10'd0);
    add_vec("neg_half",   raw(-32'sh8000), '0, '0, '0, '0, 10'd0, 10'd0);
    add_vec("edge511",    qi(256), qi(255), raw(32'h7FFF), '0, '0, 10'd511, 10'd511);
    add_vec("edge512",    qi(256), qi(255), raw(32'h8000), '0, '0, 10'd511, 10'h200);
    add_vec("edge1023",   qi(256), qi(256), qi(256), qi(255), '0, 10'd511, 10'd1023);
    add_vec("edge1024",   qi(256), qi(256), qi(256), qi(256), '0, 10'd511, 10'd1023);
    add_vec("min512",     qi(-256), qi(-256), '0, '0, '0, 10'h200, 10'd0);
    add_vec("min513",     qi(-256), qi(-257), '0, '0, '0, 10'h200, 10'd0);

    // Reset
    repeat (3) @(posedge clk);
    #1;
    check("rst_ov", 32'(out_valid), 32'd0);
    check("rst_pix", 32'(out_pixel), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Table vectors, even-indexed ones back-to-back, odd ones with input gaps
    for (int i = 0; i < vecs.size(); i++) begin
      run_pixel(vecs[i].name, vecs[i].p0, vecs[i].p1, vecs[i].p2, vecs[i].p3, vecs[i].b,
                RELU ? vecs[i].e_relu : vecs[i].e_lin, (i % 2) == 1);
    end
    bias = '0;

    // Backpressure: 10 cycles without out_ready while a beat is offered
    for (int i = 0; i < 4; i++) feed(qi(50), 0);
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    in_psum  = qi(7);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      check("bp_pix", 32'(out_pixel), 32'd200);
      check("bp_ov", 32'(out_valid), 32'd1);
      check("bp_in_ready", 32'(in_ready), 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("bp_consumed", 32'(out_valid), 32'd0);
    check("bp_busy", 32'(busy), 32'd0);
    run_pixel("bp_next", qi(10), qi(10), qi(10), qi(10), '0, 10'd40, 1'b0);

    // No bypass with out_ready held high: valid for exactly one cycle
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) feed(qi(1), 0);
    check("nb_finish_ov", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;
    check("nb_ov", 32'(out_valid), 32'd1);
    check("nb_pix", 32'(out_pixel), 32'd4);
    @(posedge clk);
    #1;
    check("nb_consumed", 32'(out_valid), 32'd0);
    check("nb_state_accum", 32'(in_ready), 32'd1);
    out_ready = 1'b0;

    // clear after beat 2 with a same-cycle beat that must be dropped
    feed(qi(123), 0);
    feed(qi(123), 0);
    check("clr_busy_before", 32'(busy), 32'd1);
    clear    = 1'b1;
    in_valid = 1'b1;
    in_psum  = qi(99);
    @(posedge clk);
    #1;
    clear    = 1'b0;
    in_valid = 1'b0;
    check("clr_ov", 32'(out_valid), 32'd0);
    check("clr_busy", 32'(busy), 32'd0);
    run_pixel("clr_next", qi(200), qi(200), qi(200), qi(200), '0,
              RELU ? 10'd800 : 10'd511, 1'b0);

    // clear in HOLD together with out_ready
    for (int i = 0; i < 4; i++) feed(qi(1), 0);
    @(posedge clk);
    #1;
    check("clrh_ov_before", 32'(out_valid), 32'd1);
    clear     = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    clear     = 1'b0;
    out_ready = 1'b0;
    check("clrh_ov", 32'(out_valid), 32'd0);
    check("clrh_busy", 32'(busy), 32'd0);
    check("clrh_in_ready", 32'(in_ready), 32'd1);
    run_pixel("clrh_next", qi(200), qi(200), qi(200), qi(200), '0,
              RELU ? 10'd800 : 10'd511, 1'b0);

    // Asynchronous reset mid-accumulation, between clock edges
    feed(qi(5), 0);
    feed(qi(5), 0);
    #1;
    rst = 1'b0;
    #1;
    check("arst_ov", 32'(out_valid), 32'd0);
    check("arst_pix", 32'(out_pixel), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    run_pixel("arst_next", qi(200), qi(200), qi(200), qi(200), '0,
              RELU ? 10'd800 : 10'd511, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
